id_pipe_stage: RTL and testbench
================================

Name: id_pipe_stage

Overview:
- Parametrised successor to the combinational decode stage.
- Wraps the existing `decoder` and field extraction, then registers the decoded result into an ID/EX pipeline register.
- Adds a valid/ready handshake on both sides, load-use hazard bubble insertion, and a flush input.
- Sits between the IF/ID register and EX; the immediate is pre-selected so EX needs no extension logic.

Parameters:
- DATA_W, 32, register/immediate data width (>= IMM_W)
- ADDR_W, 32, instruction address width
- REG_ADDR_W, 5, register index width
- IMM_W, 16, raw immediate field width (inst[IMM_W-1:0])
- CNT_W, 16, stall counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_pc_plus4  in  ADDR_W  PC+4 of the incoming instruction
- in_inst  in  32  instruction word
- flush  in  1  branch/jump redirect: squash the incoming and the held instruction
- out_ready  in  1  EX accepts this cycle
- out_valid  out  1  ID/EX register holds a valid instruction
- out_pc_plus4  out  ADDR_W  registered PC+4 (jal link)
- out_ctrl  out  CTRL_W  packed decoder controls: WriteReg, MemOrAlu, WriteMem, ReadMem, AluType, AluOp, AluSrcA, AluSrcB, RegDes, ImmSigned, is_jal
- out_rs, out_rt, out_rd  out  REG_ADDR_W each  register indices
- out_imm  out  DATA_W  immediate, sign- or zero-extended per ImmSigned
- out_shamt  out  DATA_W  zero-extended inst[10:6]
- out_opcode  out  6  inst[31:26]

Behaviour:
- Reset and clocking:
  - One clock, `clk`; synchronous active-high `rst`, sampled on the rising edge.
  - On reset: out_valid=0 and all out_* data/controls = 0.
- Latency: exactly one cycle from accept to out_valid=1.
- Definitions:
  - adv = ~out_valid | out_ready.
  - hazard = in_valid & out_valid & ReadMem(out_ctrl) & WriteReg(out_ctrl) & (out_rt != 0) & (in rs == out_rt | in rt == out_rt). The rt comparison is conservative and applies to every opcode.
  - in_ready = flush | (adv & ~hazard).
- Register update, in priority order:
  1. rst: clear everything.
  2. flush: out_valid <= 0; the incoming instruction is consumed and discarded. A flush during hazard or backpressure still clears.
  3. adv & hazard: out_valid <= 0 (bubble); the input is not consumed. Next cycle the load has left, hazard drops, and the instruction is accepted.
  4. adv & ~hazard: out_valid <= in_valid; data fields load from the decode of in_inst.
  5. ~adv: hold all outputs unchanged; in_ready=0.
- Data fields load only when an instruction is accepted. Bubbles may leave stale data with out_valid=0.
- Decoder use: the decoder's own `rst` input is tied to rst. Its output is sampled only when accepted.
- Immediate selection:
  - ImmSigned=1: replicate inst[IMM_W-1] into the upper DATA_W-IMM_W bits.
  - ImmSigned=0: upper bits are zero.
- Simultaneous flush + hazard: flush wins; no bubble accounting.
- in_valid=0 with adv: out_valid <= 0.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [CNT_W-1:0].
  - Counts cycles with in_valid & ~in_ready (hazard or backpressure, flush excluded).
  - Saturates at all-ones; reset clears it to 0.
- Undefined: the port and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds:
  - CTRL_W and the bit offsets of each field in out_ctrl.
  - Opcode, funct, bus-range constants (RsBus, RtBus, RdBus, ImmBus, SaBus, OpcodeBus).
  - ALU type/op widths.
- Sub-module: reuse the existing `decoder` unchanged.
- Hazard comparison and pipeline register stay in id_pipe_stage; no further sub-modules.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0 and out_imm=0; then in_ready=1.
- Accept, signed immediate: addi $2,$1,-1 (0x2022FFFF), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rt=2, out_rs=1, out_pc_plus4 matches the input.
- Accept, zero-extended immediate: ori with imm 0xFFFF -> out_imm=0x0000FFFF.
- Load-use: lw $3,0($1) accepted, then add $4,$3,$5 presented with out_ready=1:
  - cycle 1: in_ready=0, lw issues downstream.
  - cycle 2: out_valid=0 (bubble), add accepted.
  - cycle 3: out_valid=1, out_rd=4.
  - With ID_STALL_CNT_EN, stall_cnt=1.
- Backpressure: out_ready=0 for 3 cycles with an instruction held -> outputs stable, in_ready=0, stall_cnt increments by 3.
- Flush during hazard: lw held, dependent add waiting, flush=1 -> next cycle out_valid=0, in_ready was 1, add discarded, stall_cnt unchanged.

Source files
------------

// File: rtl/id_pipe_stage_pkg.sv
// Shared decode definitions for the ID stage: instruction bus ranges, opcodes,
// ALU encodings and the packed control word carried to EX.
package id_pipe_stage_pkg;

  localparam int unsigned INST_W        = 32;
  localparam int unsigned OPCODE_BUS_HI = 31;
  localparam int unsigned OPCODE_BUS_LO = 26;
  localparam int unsigned RS_BUS_HI     = 25;
  localparam int unsigned RS_BUS_LO     = 21;
  localparam int unsigned RT_BUS_HI     = 20;
  localparam int unsigned RT_BUS_LO     = 16;
  localparam int unsigned RD_BUS_HI     = 15;
  localparam int unsigned RD_BUS_LO     = 11;
  localparam int unsigned SA_BUS_HI     = 10;
  localparam int unsigned SA_BUS_LO     = 6;
  localparam int unsigned FUNCT_BUS_HI  = 5;
  localparam int unsigned FUNCT_BUS_LO  = 0;
  localparam int unsigned IMM_BUS_LO    = 0;

  localparam int unsigned ALU_TYPE_W = 2;
  localparam int unsigned ALU_OP_W   = 4;

  typedef enum logic [ALU_TYPE_W-1:0] {
    ALU_T_ARITH = 2'd0,
    ALU_T_LOGIC = 2'd1,
    ALU_T_SHIFT = 2'd2,
    ALU_T_CMP   = 2'd3
  } alu_type_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // First member is the MSB; the offsets below must track this order.
  typedef struct packed {
    logic      write_reg;
    logic      mem_or_alu;
    logic      write_mem;
    logic      read_mem;
    alu_type_e alu_type;
    alu_op_e   alu_op;
    logic      alu_src_a;
    logic      alu_src_b;
    logic      reg_des;
    logic      imm_signed;
    logic      is_jal;
  } ctrl_t;

  localparam int unsigned CTRL_W          = $bits(ctrl_t);
  localparam int unsigned CTRL_WRITE_REG  = 14;
  localparam int unsigned CTRL_MEM_OR_ALU = 13;
  localparam int unsigned CTRL_WRITE_MEM  = 12;
  localparam int unsigned CTRL_READ_MEM   = 11;
  localparam int unsigned CTRL_ALU_TYPE_LO = 9;
  localparam int unsigned CTRL_ALU_OP_LO  = 5;
  localparam int unsigned CTRL_ALU_SRC_A  = 4;
  localparam int unsigned CTRL_ALU_SRC_B  = 3;
  localparam int unsigned CTRL_REG_DES    = 2;
  localparam int unsigned CTRL_IMM_SIGNED = 1;
  localparam int unsigned CTRL_IS_JAL     = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // A load that writes back is the only producer EX cannot forward in time.
  function automatic logic ctrl_is_load_wb(input ctrl_t c);
    return c.read_mem & c.write_reg;
  endfunction

endpackage

// File: rtl/id_pipe_stage_decoder.sv
// Combinational opcode/funct decoder producing the packed EX control word.
// Outputs are forced to zero while rst is asserted.
module decoder
  import id_pipe_stage_pkg::*;
(
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  ctrl_t w_ctrl;

  // Opcode/funct to control-word decode; unknown encodings decode as a nop.
  always_comb begin
    w_ctrl = '0;
    if (rst) begin
      w_ctrl = '0;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          w_ctrl.reg_des   = 1'b1;
          w_ctrl.write_reg = 1'b1;
          case (funct)
            FN_ADD, FN_ADDU: w_ctrl.alu_op = ALU_ADD;
            FN_SUB, FN_SUBU: w_ctrl.alu_op = ALU_SUB;
            FN_AND: begin w_ctrl.alu_type = ALU_T_LOGIC; w_ctrl.alu_op = ALU_AND; end
            FN_OR:  begin w_ctrl.alu_type = ALU_T_LOGIC; w_ctrl.alu_op = ALU_OR;  end
            FN_XOR: begin w_ctrl.alu_type = ALU_T_LOGIC; w_ctrl.alu_op = ALU_XOR; end
            FN_NOR: begin w_ctrl.alu_type = ALU_T_LOGIC; w_ctrl.alu_op = ALU_NOR; end
            FN_SLT:  begin w_ctrl.alu_type = ALU_T_CMP; w_ctrl.alu_op = ALU_SLT;  end
            FN_SLTU: begin w_ctrl.alu_type = ALU_T_CMP; w_ctrl.alu_op = ALU_SLTU; end
            FN_SLL: begin
              w_ctrl.alu_type  = ALU_T_SHIFT;
              w_ctrl.alu_op    = ALU_SLL;
              w_ctrl.alu_src_a = 1'b1;
            end
            FN_SRL: begin
              w_ctrl.alu_type  = ALU_T_SHIFT;
              w_ctrl.alu_op    = ALU_SRL;
              w_ctrl.alu_src_a = 1'b1;
            end
            FN_SRA: begin
              w_ctrl.alu_type  = ALU_T_SHIFT;
              w_ctrl.alu_op    = ALU_SRA;
              w_ctrl.alu_src_a = 1'b1;
            end
            FN_JR: begin
              w_ctrl.reg_des   = 1'b0;
              w_ctrl.write_reg = 1'b0;
            end
            default: begin
              w_ctrl.reg_des   = 1'b0;
              w_ctrl.write_reg = 1'b0;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          w_ctrl.write_reg  = 1'b1;
          w_ctrl.alu_src_b  = 1'b1;
          w_ctrl.imm_signed = 1'b1;
        end
        OP_SLTI, OP_SLTIU: begin
          w_ctrl.write_reg  = 1'b1;
          w_ctrl.alu_type   = ALU_T_CMP;
          w_ctrl.alu_op     = (opcode == OP_SLTI) ? ALU_SLT : ALU_SLTU;
          w_ctrl.alu_src_b  = 1'b1;
          w_ctrl.imm_signed = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          w_ctrl.write_reg = 1'b1;
          w_ctrl.alu_type  = ALU_T_LOGIC;
          w_ctrl.alu_src_b = 1'b1;
          case (opcode)
            OP_ANDI: w_ctrl.alu_op = ALU_AND;
            OP_ORI:  w_ctrl.alu_op = ALU_OR;
            OP_XORI: w_ctrl.alu_op = ALU_XOR;
            default: w_ctrl.alu_op = ALU_LUI;
          endcase
        end
        OP_LW: begin
          w_ctrl.write_reg  = 1'b1;
          w_ctrl.mem_or_alu = 1'b1;
          w_ctrl.read_mem   = 1'b1;
          w_ctrl.alu_src_b  = 1'b1;
          w_ctrl.imm_signed = 1'b1;
        end
        OP_SW: begin
          w_ctrl.write_mem  = 1'b1;
          w_ctrl.alu_src_b  = 1'b1;
          w_ctrl.imm_signed = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          w_ctrl.alu_op     = ALU_SUB;
          w_ctrl.imm_signed = 1'b1;
        end
        OP_JAL: begin
          w_ctrl.write_reg = 1'b1;
          w_ctrl.is_jal    = 1'b1;
        end
        OP_J:    w_ctrl = '0;
        default: w_ctrl = '0;
      endcase
    end
  end

  assign ctrl = w_ctrl;

endmodule

// File: rtl/id_pipe_stage.sv
// ID stage: decode plus ID/EX pipeline register with valid/ready, load-use bubbles
// and flush. Optional stall counter port enabled by defining ID_STALL_CNT_EN.
module id_pipe_stage
  import id_pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_pc_plus4,
  input  logic [INST_W-1:0]     in_inst,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ADDR_W-1:0]     out_pc_plus4,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_imm,
  output logic [DATA_W-1:0]     out_shamt,
  output logic [5:0]            out_opcode
`ifdef ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  ctrl_t                 w_dec_ctrl;
  logic [REG_ADDR_W-1:0] w_in_rs;
  logic [REG_ADDR_W-1:0] w_in_rt;
  logic [REG_ADDR_W-1:0] w_in_rd;
  logic [DATA_W-1:0]     w_imm;
  logic                  w_adv;
  logic                  w_hazard;
  logic                  w_in_ready;

  logic                  r_valid;
  logic [ADDR_W-1:0]     r_pc_plus4;
  ctrl_t                 r_ctrl;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_imm;
  logic [DATA_W-1:0]     r_shamt;
  logic [5:0]            r_opcode;

  decoder u_decoder (
    .rst    (rst),
    .opcode (in_inst[OPCODE_BUS_HI:OPCODE_BUS_LO]),
    .funct  (in_inst[FUNCT_BUS_HI:FUNCT_BUS_LO]),
    .ctrl   (w_dec_ctrl)
  );

  assign w_in_rs = REG_ADDR_W'(in_inst[RS_BUS_HI:RS_BUS_LO]);
  assign w_in_rt = REG_ADDR_W'(in_inst[RT_BUS_HI:RT_BUS_LO]);
  assign w_in_rd = REG_ADDR_W'(in_inst[RD_BUS_HI:RD_BUS_LO]);

  // Extension is done here so EX sees a ready-to-use operand.
  always_comb begin
    w_imm = {DATA_W{1'b0}};
    if (w_dec_ctrl.imm_signed) begin
      w_imm = DATA_W'($signed(in_inst[IMM_W-1:IMM_BUS_LO]));
    end else begin
      w_imm = DATA_W'(in_inst[IMM_W-1:IMM_BUS_LO]);
    end
  end

  assign w_adv = ~r_valid | out_ready;

  // The rt match is deliberately conservative and ignores whether rt is read.
  assign w_hazard = in_valid & r_valid & ctrl_is_load_wb(r_ctrl)
                  & (r_rt != {REG_ADDR_W{1'b0}})
                  & ((w_in_rs == r_rt) | (w_in_rt == r_rt));

  assign w_in_ready = flush | (w_adv & ~w_hazard);
  assign in_ready   = w_in_ready;

  // ID/EX register: reset, flush, bubble, accept, or hold, in that priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc_plus4 <= {ADDR_W{1'b0}};
      r_ctrl     <= '0;
      r_rs       <= {REG_ADDR_W{1'b0}};
      r_rt       <= {REG_ADDR_W{1'b0}};
      r_rd       <= {REG_ADDR_W{1'b0}};
      r_imm      <= {DATA_W{1'b0}};
      r_shamt    <= {DATA_W{1'b0}};
      r_opcode   <= 6'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_pc_plus4 <= in_pc_plus4;
          r_ctrl     <= w_dec_ctrl;
          r_rs       <= w_in_rs;
          r_rt       <= w_in_rt;
          r_rd       <= w_in_rd;
          r_imm      <= w_imm;
          r_shamt    <= DATA_W'(in_inst[SA_BUS_HI:SA_BUS_LO]);
          r_opcode   <= in_inst[OPCODE_BUS_HI:OPCODE_BUS_LO];
        end else begin
          r_opcode <= r_opcode;
        end
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_valid    = r_valid;
  assign out_pc_plus4 = r_pc_plus4;
  assign out_ctrl     = r_ctrl;
  assign out_rs       = r_rs;
  assign out_rt       = r_rt;
  assign out_rd       = r_rd;
  assign out_imm      = r_imm;
  assign out_shamt    = r_shamt;
  assign out_opcode   = r_opcode;

`ifdef ID_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Flush forces in_ready high, so flush cycles never count as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (in_valid & ~w_in_ready & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: vector table plus load-use, backpressure
// and flush sequences. Stall counter checks are active with ID_STALL_CNT_EN.
module tb_id_pipe_stage;
  import id_pipe_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc_plus4;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [31:0] out_shamt;
  logic [5:0]  out_opcode;
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks;
  int n_errors;
  int exp_stall;

  id_pipe_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc_plus4  (in_pc_plus4),
    .in_inst      (in_inst),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_pc_plus4 (out_pc_plus4),
    .out_ctrl     (out_ctrl),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_shamt    (out_shamt),
    .out_opcode   (out_opcode)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ordy;
    logic        exp_in_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rs;
    logic [4:0]  exp_rt;
    logic [4:0]  exp_rd;
    logic [14:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall();
`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_stall = 0;

    //            valid inst          pc         ordy rdy vld dat imm           rs     rt     rd     ctrl
    vecs[0] = '{1'b1, 32'h2022FFFF, 32'h1004, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd31, 15'h400A};
    vecs[1] = '{1'b1, 32'h3423FFFF, 32'h1008, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000FFFF, 5'd1, 5'd3, 5'd31, 15'h4268};
    vecs[2] = '{1'b0, 32'h00000000, 32'h100C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  15'h0};
    vecs[3] = '{1'b1, 32'h20E67FFF, 32'h1010, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00007FFF, 5'd7, 5'd6, 5'd15, 15'h400A};
    vecs[4] = '{1'b1, 32'hAC450004, 32'h1014, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000004, 5'd2, 5'd5, 5'd0,  15'h100A};
    vecs[5] = '{1'b1, 32'h8C200000, 32'h1018, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000, 5'd1, 5'd0, 5'd0,  15'h680A};
    vecs[6] = '{1'b1, 32'h00052020, 32'h101C, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00002020, 5'd0, 5'd5, 5'd4,  15'h4004};
    vecs[7] = '{1'b1, 32'h8C230000, 32'h1020, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000, 5'd1, 5'd3, 5'd0,  15'h680A};
    vecs[8] = '{1'b1, 32'hAC430000, 32'h1024, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  15'h0};
    vecs[9] = '{1'b1, 32'hAC430000, 32'h1024, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000, 5'd2, 5'd3, 5'd0,  15'h100A};

    // Reset held two cycles with a valid instruction offered.
    rst = 1'b1; in_valid = 1'b1; in_inst = 32'h2022FFFF; in_pc_plus4 = 32'h0FFC;
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_stall();

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].valid; in_inst = vecs[i].inst;
      in_pc_plus4 = vecs[i].pc; out_ready = vecs[i].ordy; flush = 1'b0;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      if (vecs[i].valid && !vecs[i].exp_in_ready) exp_stall++;
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_imm", i), out_imm, vecs[i].exp_imm);
        chk($sformatf("v%0d_rs", i), 32'(out_rs), 32'(vecs[i].exp_rs));
        chk($sformatf("v%0d_rt", i), 32'(out_rt), 32'(vecs[i].exp_rt));
        chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].exp_rd));
        chk($sformatf("v%0d_pc", i), out_pc_plus4, vecs[i].pc);
        chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].exp_ctrl));
        chk($sformatf("v%0d_opcode", i), 32'(out_opcode), 32'(vecs[i].inst[31:26]));
      end
    end
    chk_stall();

    // Load-use: lw $3 then add $4,$3,$5.
    in_valid = 1'b1; in_inst = 32'h8C230000; in_pc_plus4 = 32'h2004; out_ready = 1'b1;
    #1;
    chk("lu_lw_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_inst = 32'h00652020; in_pc_plus4 = 32'h2008;
    #1;
    chk("lu_c1_in_ready", 32'(in_ready), 32'd0);
    chk("lu_c1_out_valid", 32'(out_valid), 32'd1);
    chk("lu_c1_out_rt", 32'(out_rt), 32'd3);
    exp_stall++;
    tick();
    chk("lu_c2_bubble", 32'(out_valid), 32'd0);
    #1;
    chk("lu_c2_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu_c3_out_valid", 32'(out_valid), 32'd1);
    chk("lu_c3_out_rd", 32'(out_rd), 32'd4);
    chk("lu_c3_pc", out_pc_plus4, 32'h2008);
    chk("lu_c3_imm", out_imm, 32'h00002020);
    chk_stall();

    // Backpressure: EX refuses for three cycles while add is held.
    in_inst = 32'h2022FFFF; in_pc_plus4 = 32'h200C; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      exp_stall++;
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_rd", 32'(out_rd), 32'd4);
      chk("bp_out_pc", out_pc_plus4, 32'h2008);
    end
    chk_stall();
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_release_imm", out_imm, 32'hFFFFFFFF);
    chk("bp_release_pc", out_pc_plus4, 32'h200C);

    // Flush while a dependent add waits behind a held lw.
    in_inst = 32'h8C230000; in_pc_plus4 = 32'h3004; out_ready = 1'b1;
    #1;
    tick();
    in_inst = 32'h00652020; in_pc_plus4 = 32'h3008; out_ready = 1'b0;
    #1;
    chk("fl_wait_in_ready", 32'(in_ready), 32'd0);
    exp_stall++;
    tick();
    chk("fl_lw_held", out_pc_plus4, 32'h3004);
    chk_stall();
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk_stall();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tick();
    chk("fl_add_discarded_valid", 32'(out_valid), 32'd0);
    chk("fl_add_discarded_pc", out_pc_plus4, 32'h3004);

    // Flush with a non-hazard instruction offered also discards it.
    in_valid = 1'b1; in_inst = 32'h2022FFFF; in_pc_plus4 = 32'h4004; flush = 1'b1;
    #1;
    tick();
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
    chk("fl2_pc_kept", out_pc_plus4, 32'h3004);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tick();
    chk_stall();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
